// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, datapath types and the MAC state enum for the
// 3x3 convolution window MAC (conv_window_mac and conv_row_mult).
// No ports; imported by every file of the block.
package conv_pkg;

    localparam int SAMPLE_W   = 8;
    localparam int COEFF_W    = 8;
    localparam int ACC_W      = SAMPLE_W + COEFF_W + 5;
    localparam int KERNEL_DIM = 3;

    typedef logic        [SAMPLE_W-1:0] sample_t;
    typedef logic signed [COEFF_W-1:0]  coeff_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    // One kernel row; element [c] is column c, matching the bus packing.
    typedef logic [KERNEL_DIM-1:0][SAMPLE_W-1:0] sample_row_t;
    typedef logic [KERNEL_DIM-1:0][COEFF_W-1:0]  coeff_row_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROW0,
        ST_ROW1,
        ST_ROW2
    } mac_state_t;

endpackage

// File: rtl/conv_window_mac_if.sv
// conv_window_mac_if: groups the coefficient-load, sample-shift, start and
// result signals of conv_window_mac.
//   master : upstream controller (drives loads/shifts/starts, sees results)
//   slave  : the MAC itself
interface conv_window_mac_if;
    import conv_pkg::*;

    logic                         coeff_ld;
    logic [1:0]                   coeff_sel;
    logic [3*COEFF_W-1:0]         coeff_data;
    logic                         sample_shift;
    logic [3*SAMPLE_W-1:0]        sample_data;
    logic                         sample_stream;
    logic                         convolve_en;
    logic                         busy;
    acc_t                         result;
    logic                         result_valid;
    logic                         err;

    modport master (
        output coeff_ld, coeff_sel, coeff_data,
        output sample_shift, sample_data,
        output sample_stream, convolve_en,
        input  busy, result, result_valid, err
    );

    modport slave (
        input  coeff_ld, coeff_sel, coeff_data,
        input  sample_shift, sample_data,
        input  sample_stream, convolve_en,
        output busy, result, result_valid, err
    );

endinterface

// File: rtl/conv_window_mac_row_mult.sv
// conv_row_mult: combinational partial sum of one kernel row.
//   i_coeff  : three signed coefficients of the row
//   i_sample : three unsigned shadow samples of the row
//   o_sum    : signed sum of the three products
module conv_row_mult
    import conv_pkg::*;
(
    input  coeff_row_t  i_coeff,
    input  sample_row_t i_sample,
    output acc_t        o_sum
);

    acc_t w_prod [KERNEL_DIM];

    always_comb begin
        for (int c = 0; c < KERNEL_DIM; c++) begin
            // Sample zero-extends (unsigned source), coefficient sign-extends.
            w_prod[c] = acc_t'(i_sample[c]) * acc_t'(coeff_t'(i_coeff[c]));
        end
        o_sum = w_prod[0] + w_prod[1] + w_prod[2];
    end

endmodule

// File: rtl/conv_window_mac.sv
// conv_window_mac: 3x3 coefficient bank, 3x3 sliding sample window and a
// three-cycle row-serial signed MAC with a one-cycle result_valid pulse.
//   clk, rst : clock and synchronous active-high reset
//   bus      : conv_window_mac_if.slave (loads, shifts, start, result, err)
// Build option: CONV_CLAMP_EN clamps result to 0..2^SAMPLE_W-1.
//
// state | meaning
// IDLE  | waiting for an accepted start
// ROW0  | accumulate kernel row 0
// ROW1  | accumulate kernel row 1
// ROW2  | add row 2, register result, pulse result_valid
module conv_window_mac
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    conv_window_mac_if.slave bus
);

    localparam acc_t CLAMP_MAX = acc_t'((1 << SAMPLE_W) - 1);

    mac_state_t  r_state;
    mac_state_t  w_state_nxt;
    logic [1:0]  r_fill;
    sample_row_t r_win    [KERNEL_DIM];
    sample_row_t r_shadow [KERNEL_DIM];
    coeff_row_t  r_coeff  [KERNEL_DIM];
    acc_t        r_acc;
    acc_t        r_result;
    logic        r_valid;
    logic        r_err;

    logic        w_req;
    logic        w_start;
    logic        w_bad_sel;
    coeff_row_t  w_coeff_row;
    sample_row_t w_shadow_row;
    sample_row_t w_samp_in;
    acc_t        w_row_sum;
    acc_t        w_final;
    acc_t        w_result_nxt;

    assign w_samp_in = bus.sample_data;
    assign w_req     = bus.convolve_en && bus.sample_stream;
    assign w_bad_sel = bus.coeff_ld && (bus.coeff_sel == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_coeff_row  = r_coeff[0];
        w_shadow_row = r_shadow[0];
        case (r_state)
            ST_IDLE: begin
                if (w_req && (r_fill == 2'd3)) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_ROW0;
                end
            end
            ST_ROW0: w_state_nxt = ST_ROW1;
            ST_ROW1: begin
                w_coeff_row  = r_coeff[1];
                w_shadow_row = r_shadow[1];
                w_state_nxt  = ST_ROW2;
            end
            ST_ROW2: begin
                w_coeff_row  = r_coeff[2];
                w_shadow_row = r_shadow[2];
                w_state_nxt  = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    conv_row_mult u_row_mult (
        .i_coeff  (w_coeff_row),
        .i_sample (w_shadow_row),
        .o_sum    (w_row_sum)
    );

    assign w_final = r_acc + w_row_sum;

`ifdef CONV_CLAMP_EN
    always_comb begin
        w_result_nxt = w_final;
        if (w_final[ACC_W-1])           w_result_nxt = '0;
        else if (w_final > CLAMP_MAX)   w_result_nxt = CLAMP_MAX;
    end
`else
    assign w_result_nxt = w_final;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            for (int r = 0; r < KERNEL_DIM; r++) begin
                r_win[r]    <= '0;
                r_shadow[r] <= '0;
                r_coeff[r]  <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            // Any rejected qualified start is a protocol error (busy or fill<3).
            if ((w_req && !w_start) || w_bad_sel) r_err <= 1'b1;

            if (bus.sample_shift) begin
                for (int r = 0; r < KERNEL_DIM; r++) begin
                    r_win[r] <= {w_samp_in[r], r_win[r][2], r_win[r][1]};
                end
                if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
            end

            if (bus.coeff_ld && !w_bad_sel) r_coeff[bus.coeff_sel] <= bus.coeff_data;

            // Shadow takes the pre-shift window even when a shift lands on the same edge.
            if (w_start) begin
                r_shadow <= r_win;
                r_acc    <= '0;
            end

            case (r_state)
                ST_ROW0, ST_ROW1: r_acc <= w_final;
                ST_ROW2: begin
                    r_result <= w_result_nxt;
                    r_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;
    assign bus.err          = r_err;

endmodule

// File: tb/tb_conv_window_mac.sv
// tb_conv_window_mac: self-checking bench for conv_window_mac. Table vectors,
// hand-written corner sequences and random windows checked against a plain
// arithmetic 3x3 dot-product model.
module tb_conv_window_mac;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst;

    conv_window_mac_if u_if ();

    conv_window_mac u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int m_coeff [3][3];
    int m_win   [3][3];

    typedef struct {
        string       name;
        logic [71:0] coeff;
        logic [71:0] samp;
        longint      exp_raw;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic longint expect_of(input longint raw);
`ifdef CONV_CLAMP_EN
        if (raw < 0)   return 0;
        if (raw > 255) return 255;
`endif
        return raw;
    endfunction

    function automatic logic [71:0] p9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic longint model_sum();
        longint s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += longint'(m_coeff[r][c]) * longint'(m_win[r][c]);
        return s;
    endfunction

    task automatic model_shift(input int s0, s1, s2);
        int col [3];
        col[0] = s0; col[1] = s1; col[2] = s2;
        for (int r = 0; r < 3; r++) begin
            m_win[r][0] = m_win[r][1];
            m_win[r][1] = m_win[r][2];
            m_win[r][2] = col[r];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.coeff_ld      = 1'b0;
        u_if.coeff_sel     = 2'd0;
        u_if.coeff_data    = '0;
        u_if.sample_shift  = 1'b0;
        u_if.sample_data   = '0;
        u_if.sample_stream = 1'b0;
        u_if.convolve_en   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                m_coeff[r][c] = 0;
                m_win[r][c]   = 0;
            end
    endtask

    task automatic load_row(input int sel, input int c0, c1, c2);
        u_if.coeff_ld   = 1'b1;
        u_if.coeff_sel  = 2'(sel);
        u_if.coeff_data = {8'(c2), 8'(c1), 8'(c0)};
        tick();
        u_if.coeff_ld = 1'b0;
        if (sel < 3) begin
            m_coeff[sel][0] = c0;
            m_coeff[sel][1] = c1;
            m_coeff[sel][2] = c2;
        end
    endtask

    task automatic shift_col(input int s0, s1, s2);
        u_if.sample_shift = 1'b1;
        u_if.sample_data  = {8'(s2), 8'(s1), 8'(s0)};
        tick();
        u_if.sample_shift = 1'b0;
        model_shift(s0, s1, s2);
    endtask

    // Presents one start, then watches 8 cycles after the acceptance edge.
    task automatic run_mac(input bit shift_at_start, input bit shift_busy,
                           output logic signed [63:0] res, output int busy_n, output int valid_n);
        u_if.convolve_en   = 1'b1;
        u_if.sample_stream = 1'b1;
        if (shift_at_start) begin
            u_if.sample_shift = 1'b1;
            u_if.sample_data  = {3{8'd99}};
            model_shift(99, 99, 99);
        end
        tick();
        u_if.convolve_en   = 1'b0;
        u_if.sample_stream = 1'b0;
        u_if.sample_shift  = 1'b0;
        busy_n  = 0;
        valid_n = 0;
        res     = 'x;
        for (int i = 0; i < 8; i++) begin
            if (u_if.busy) busy_n++;
            if (u_if.result_valid) begin
                valid_n++;
                res = u_if.result;
            end
            if (i == 0 && shift_busy) begin
                u_if.sample_shift = 1'b1;
                u_if.sample_data  = {3{8'd50}};
                model_shift(50, 50, 50);
            end
            tick();
            u_if.sample_shift = 1'b0;
        end
    endtask

    task automatic run_and_check(input string name, input longint exp_val,
                                 input bit shift_at_start, input bit shift_busy);
        logic signed [63:0] res;
        int bn, vn;
        run_mac(shift_at_start, shift_busy, res, bn, vn);
        chk({name, " result"}, res, exp_val);
        chk({name, " busy_cycles"}, bn, 3);
        chk({name, " valid_pulses"}, vn, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [63:0] res;
        int bn, vn;

        vecs[0] = '{"ones10",   p9(1,1,1,1,1,1,1,1,1), p9(10,10,10,10,10,10,10,10,10), 90};
        vecs[1] = '{"identity", p9(0,0,0,0,1,0,0,0,0), p9(1,2,3,4,5,6,7,8,9), 5};
        vecs[2] = '{"sobel_x",  p9(-1,0,1,-2,0,2,-1,0,1), p9(200,0,0,200,0,0,200,0,0), -800};
        vecs[3] = '{"neg_max",  p9(-128,-128,-128,-128,-128,-128,-128,-128,-128),
                                p9(255,255,255,255,255,255,255,255,255), -293760};
        vecs[4] = '{"pos_max",  p9(127,127,127,127,127,127,127,127,127),
                                p9(255,255,255,255,255,255,255,255,255), 291465};
        vecs[5] = '{"ramp",     p9(1,2,3,4,5,6,7,8,9), p9(1,1,1,1,1,1,1,1,1), 45};
        vecs[6] = '{"mid180",   p9(1,1,1,1,1,1,1,1,1), p9(20,20,20,20,20,20,20,20,20), 180};
        vecs[7] = '{"sum255",   p9(1,1,1,1,1,1,1,1,1), p9(31,28,28,28,28,28,28,28,28), 255};
        vecs[8] = '{"sum256",   p9(1,1,1,1,1,1,1,1,1), p9(32,28,28,28,28,28,28,28,28), 256};

        // Reset state
        do_reset();
        chk("reset busy", u_if.busy, 0);
        chk("reset result", u_if.result, 0);
        chk("reset valid", u_if.result_valid, 0);
        chk("reset err", u_if.err, 0);

        // Unqualified start: ignored, no error even with fill 0
        u_if.convolve_en   = 1'b1;
        u_if.sample_stream = 1'b0;
        tick();
        u_if.convolve_en = 1'b0;
        chk("nostream busy", u_if.busy, 0);
        tick();
        chk("nostream err", u_if.err, 0);

        // Table vectors
        foreach (vecs[i]) begin
            for (int r = 0; r < 3; r++)
                load_row(r, int'($signed(vecs[i].coeff[8*(r*3+0) +: 8])),
                            int'($signed(vecs[i].coeff[8*(r*3+1) +: 8])),
                            int'($signed(vecs[i].coeff[8*(r*3+2) +: 8])));
            for (int c = 0; c < 3; c++)
                shift_col(int'(vecs[i].samp[8*(0*3+c) +: 8]),
                          int'(vecs[i].samp[8*(1*3+c) +: 8]),
                          int'(vecs[i].samp[8*(2*3+c) +: 8]));
            run_and_check(vecs[i].name, expect_of(vecs[i].exp_raw), 1'b0, 1'b0);
        end
        chk("table err", u_if.err, 0);
        chk("result held", u_if.result, expect_of(256));

        // Identity kernel, shift during busy must not disturb the shadow
        load_row(0, 0, 0, 0);
        load_row(1, 0, 1, 0);
        load_row(2, 0, 0, 0);
        for (int c = 0; c < 3; c++) shift_col(c*3+1, c*3+2, c*3+3);
        run_and_check("id_shift_busy", 5, 1'b0, 1'b1);
        // Shift on the acceptance edge: pre-shift centre (5), not post-shift (8)
        for (int c = 0; c < 3; c++) shift_col(c*3+1, c*3+2, c*3+3);
        run_and_check("id_shift_start", 5, 1'b1, 1'b0);
        chk("identity err", u_if.err, 0);

        // Illegal coefficient row select
        do_reset();
        for (int r = 0; r < 3; r++) load_row(r, 1, 1, 1);
        load_row(3, 5, 5, 5);
        chk("sel3 err", u_if.err, 1);
        for (int c = 0; c < 3; c++) shift_col(10, 10, 10);
        run_and_check("sel3 nochange", 90, 1'b0, 1'b0);

        // Start with only two columns shifted in
        do_reset();
        for (int r = 0; r < 3; r++) load_row(r, 1, 1, 1);
        shift_col(10, 10, 10);
        shift_col(10, 10, 10);
        run_mac(1'b0, 1'b0, res, bn, vn);
        chk("fill2 valid_pulses", vn, 0);
        chk("fill2 busy_cycles", bn, 0);
        chk("fill2 err", u_if.err, 1);

        // Start while busy: ignored, flagged, first result unaffected
        do_reset();
        for (int r = 0; r < 3; r++) load_row(r, 1, 1, 1);
        for (int c = 0; c < 3; c++) shift_col(10, 10, 10);
        u_if.convolve_en   = 1'b1;
        u_if.sample_stream = 1'b1;
        tick();
        chk("busystart err_before", u_if.err, 0);
        tick();
        u_if.convolve_en   = 1'b0;
        u_if.sample_stream = 1'b0;
        chk("busystart err", u_if.err, 1);
        vn  = 0;
        res = 'x;
        for (int i = 0; i < 8; i++) begin
            if (u_if.result_valid) begin
                vn++;
                res = u_if.result;
            end
            tick();
        end
        chk("busystart valid_pulses", vn, 1);
        chk("busystart result", res, 90);

        // Reset in ROW1 aborts with no valid pulse
        do_reset();
        for (int r = 0; r < 3; r++) load_row(r, 1, 1, 1);
        for (int c = 0; c < 3; c++) shift_col(10, 10, 10);
        u_if.convolve_en   = 1'b1;
        u_if.sample_stream = 1'b1;
        tick();
        u_if.convolve_en   = 1'b0;
        u_if.sample_stream = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", u_if.busy, 0);
        chk("abort result", u_if.result, 0);
        vn = 0;
        for (int i = 0; i < 5; i++) begin
            if (u_if.result_valid) vn++;
            tick();
        end
        chk("abort valid_pulses", vn, 0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                m_coeff[r][c] = 0;
                m_win[r][c]   = 0;
            end
        run_mac(1'b0, 1'b0, res, bn, vn);
        chk("post_reset start err", u_if.err, 1);
        chk("post_reset valid_pulses", vn, 0);

        // Random windows and kernels against the dot-product model
        do_reset();
        for (int it = 0; it < 25; it++) begin
            longint exp_val;
            for (int r = 0; r < 3; r++)
                load_row(r, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                            int'($urandom_range(255)) - 128);
            for (int k = 0; k < 3 + int'($urandom_range(2)); k++)
                shift_col(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)));
            exp_val = expect_of(model_sum());
            run_and_check($sformatf("rand%0d", it), exp_val, 1'b0, 1'($urandom_range(1)));
        end
        chk("random err", u_if.err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
